// File: rtl/muxn_reg_pkg.sv
// Shared definitions for the channel muxes: mode encodings and select-width helper.
package muxn_reg_pkg;

  typedef enum int unsigned {
    MODE_SEL = 0,
    MODE_RR  = 1
  } mode_e;

  // Select/index width: max(1, clog2(n))
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester found searching upward from i_ptr, wrapping at CHANNELS-1.
module rr_arbiter
  import muxn_reg_pkg::*;
#(
  parameter int unsigned CHANNELS = 4
) (
  input  logic [CHANNELS-1:0]          i_req,
  input  logic [sel_w(CHANNELS)-1:0]   i_ptr,
  output logic [CHANNELS-1:0]          o_grant_c,
  output logic [sel_w(CHANNELS)-1:0]   o_idx_c
);

  localparam int unsigned SW = sel_w(CHANNELS);
  localparam int unsigned CW = SW + 1;

  logic [CW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int unsigned off = 0; off < CHANNELS; off++) begin
      // one extra bit so ptr+off never overflows before the wrap subtract
      w_cand = {1'b0, i_ptr} + CW'(off);
      if (w_cand >= CW'(CHANNELS)) begin
        w_cand = w_cand - CW'(CHANNELS);
      end
      if (!w_found && i_req[w_cand[SW-1:0]]) begin
        w_found                     = 1'b1;
        o_grant_c[w_cand[SW-1:0]]   = 1'b1;
        o_idx_c                     = w_cand[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/muxn_reg.sv
// N-channel mux into a single registered output stage, with explicit select or
// round-robin arbitration chosen by MODE.
module muxn_reg
  import muxn_reg_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MODE     = MODE_SEL
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNELS*WIDTH-1:0]   in_data,
  input  logic [CHANNELS-1:0]         in_valid,
  output logic [CHANNELS-1:0]         in_ready,
  input  logic [sel_w(CHANNELS)-1:0]  sel,
  output logic [WIDTH-1:0]            out_data,
  output logic [sel_w(CHANNELS)-1:0]  out_chan,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int unsigned SW = sel_w(CHANNELS);

  logic                w_can_load;
  logic                w_load;
  logic [CHANNELS-1:0] w_grant;
  logic [SW-1:0]       w_idx;
  logic [WIDTH-1:0]    w_masked [CHANNELS];
  logic [WIDTH-1:0]    w_sel_data;

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [SW-1:0]       r_out_chan;

  // Output stage can take a beat when empty or being drained this cycle
  assign w_can_load = ~r_out_valid | out_ready;
  assign in_ready   = w_grant & {CHANNELS{w_can_load & rst_n}};
  assign w_load     = |(in_ready & in_valid);

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SW-1:0] r_ptr;
      logic          w_unused_sel;

      assign w_unused_sel = ^sel;

      rr_arbiter #(
        .CHANNELS (CHANNELS)
      ) u_arb (
        .i_req     (in_valid),
        .i_ptr     (r_ptr),
        .o_grant_c (w_grant),
        .o_idx_c   (w_idx)
      );

      // Pointer moves past the winner only when a beat is actually accepted
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ptr <= '0;
        end else if (w_load) begin
          r_ptr <= (w_idx == SW'(CHANNELS - 1)) ? '0 : w_idx + SW'(1);
        end
      end
    end else begin : g_sel
      // Out-of-range sel matches no channel, so nothing is granted
      for (genvar i = 0; i < CHANNELS; i++) begin : g_dec
        assign w_grant[i] = (sel == SW'(i));
      end
      assign w_idx = sel;
    end
  endgenerate

  for (genvar i = 0; i < CHANNELS; i++) begin : g_mask
    assign w_masked[i] = in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}};
  end

  always_comb begin
    w_sel_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_sel_data = w_sel_data | w_masked[i];
    end
  end

  // Single output register; data/chan only change on a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
    end else if (w_can_load) begin
      r_out_valid <= w_load;
      if (w_load) begin
        r_out_data <= w_sel_data;
        r_out_chan <= w_idx;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_muxn_reg.sv
// Bench for muxn_reg: three instances (select x4, round-robin x4, select x3) checked
// against directed vector tables and a behavioural model under random traffic.
module tb_muxn_reg;

  localparam int unsigned W    = 32;
  localparam int          NDUT = 3;

  typedef struct {
    int          dut;
    logic [3:0]  valid;
    logic [1:0]  sel;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [1:0]  exp_chan;
    int          src_row;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4*W-1:0] t_data  [NDUT];
  logic [3:0]     t_valid [NDUT];
  logic [1:0]     t_sel   [NDUT];
  logic           t_ordy  [NDUT];

  logic [W-1:0]   o_data  [NDUT];
  logic [1:0]     o_chan  [NDUT];
  logic           o_valid [NDUT];
  logic [3:0]     o_inr   [NDUT];
  logic [2:0]     w_inr_c;

  assign o_inr[2] = {1'b0, w_inr_c};

  muxn_reg #(.WIDTH(W), .CHANNELS(4), .MODE(0)) u_sel4 (
    .clk(clk), .rst_n(rst_n), .in_data(t_data[0]), .in_valid(t_valid[0]),
    .in_ready(o_inr[0]), .sel(t_sel[0]), .out_data(o_data[0]), .out_chan(o_chan[0]),
    .out_valid(o_valid[0]), .out_ready(t_ordy[0]));

  muxn_reg #(.WIDTH(W), .CHANNELS(4), .MODE(1)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_data(t_data[1]), .in_valid(t_valid[1]),
    .in_ready(o_inr[1]), .sel(t_sel[1]), .out_data(o_data[1]), .out_chan(o_chan[1]),
    .out_valid(o_valid[1]), .out_ready(t_ordy[1]));

  muxn_reg #(.WIDTH(W), .CHANNELS(3), .MODE(0)) u_sel3 (
    .clk(clk), .rst_n(rst_n), .in_data(t_data[2][3*W-1:0]), .in_valid(t_valid[2][2:0]),
    .in_ready(w_inr_c), .sel(t_sel[2]), .out_data(o_data[2]), .out_chan(o_chan[2]),
    .out_valid(o_valid[2]), .out_ready(t_ordy[2]));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one held beat per instance plus the round-robin pointer
  bit           m_valid [NDUT];
  logic [W-1:0] m_data  [NDUT];
  int           m_chan  [NDUT];
  int           m_ptr   [NDUT];

  function automatic int ch_of(int d);
    return (d == 2) ? 3 : 4;
  endfunction

  function automatic int md_of(int d);
    return (d == 1) ? 1 : 0;
  endfunction

  function automatic logic [W-1:0] dat(int row, int c);
    if (row < 0) return '0;
    if (row == 0 && c == 2) return 32'hDEADBEEF;
    return {8'hA5, 8'(row), 8'h5A, 8'(c)};
  endfunction

  function automatic int grant_of(int d);
    if (md_of(d) == 0) return (int'(t_sel[d]) < ch_of(d)) ? int'(t_sel[d]) : -1;
    for (int k = 0; k < ch_of(d); k++) begin
      int c;
      c = (m_ptr[d] + k) % ch_of(d);
      if (t_valid[d][c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(int d);
    int   g;
    logic can;
    if (!rst_n) return 4'b0;
    can = !m_valid[d] || t_ordy[d];
    g   = grant_of(d);
    if (!can || g < 0) return 4'b0;
    return 4'(1 << g);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_valid[d] = 1'b0;
      m_data[d]  = '0;
      m_chan[d]  = 0;
      m_ptr[d]   = 0;
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < NDUT; d++) begin
      logic [3:0] r;
      logic       can;
      int         g;
      r   = exp_ready(d);
      can = !m_valid[d] || t_ordy[d];
      g   = grant_of(d);
      if (can) begin
        if ((r & t_valid[d]) != 4'b0) begin
          m_valid[d] = 1'b1;
          m_data[d]  = t_data[d][g*W +: W];
          m_chan[d]  = g;
          if (md_of(d) == 1) m_ptr[d] = (g + 1) % ch_of(d);
        end else begin
          m_valid[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < NDUT; d++) begin
      chk("model_in_ready",  d, 32'(o_inr[d]),   32'(exp_ready(d)));
      chk("model_out_valid", d, 32'(o_valid[d]), 32'(m_valid[d]));
      chk("model_out_chan",  d, 32'(o_chan[d]),  32'(m_chan[d]));
      chk("model_out_data",  d, o_data[d],       m_data[d]);
    end
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int d = 0; d < NDUT; d++) begin
      t_valid[d] = 4'b0;
      t_sel[d]   = 2'd0;
      t_ordy[d]  = 1'b1;
    end
  endtask

  task automatic async_reset_pulse();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl [21];

  initial begin
    tbl[0]  = '{0, 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2, 0};
    tbl[1]  = '{0, 4'b0100, 2'd2, 1'b0, 4'b0000, 1'b1, 2'd2, 0};
    tbl[2]  = '{0, 4'b0100, 2'd2, 1'b0, 4'b0000, 1'b1, 2'd2, 0};
    tbl[3]  = '{0, 4'b0100, 2'd2, 1'b0, 4'b0000, 1'b1, 2'd2, 0};
    tbl[4]  = '{0, 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2, 4};
    tbl[5]  = '{0, 4'b0010, 2'd1, 1'b1, 4'b0010, 1'b1, 2'd1, 5};
    tbl[6]  = '{0, 4'b0000, 2'd1, 1'b1, 4'b0010, 1'b0, 2'd1, 5};
    tbl[7]  = '{0, 4'b1000, 2'd0, 1'b0, 4'b0001, 1'b0, 2'd1, 5};
    tbl[8]  = '{1, 4'b1111, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 8};
    tbl[9]  = '{1, 4'b1111, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 9};
    tbl[10] = '{1, 4'b1111, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 10};
    tbl[11] = '{1, 4'b1111, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 11};
    tbl[12] = '{1, 4'b1111, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 12};
    tbl[13] = '{1, 4'b0100, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 13};
    tbl[14] = '{1, 4'b0010, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 14};
    tbl[15] = '{1, 4'b1111, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 15};
    tbl[16] = '{1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd2, 15};
    tbl[17] = '{1, 4'b0000, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd2, 15};
    tbl[18] = '{2, 4'b0111, 2'd3, 1'b1, 4'b0000, 1'b0, 2'd0, -1};
    tbl[19] = '{2, 4'b0111, 2'd3, 1'b0, 4'b0000, 1'b0, 2'd0, -1};
    tbl[20] = '{2, 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2, 20};

    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) t_data[d] = '0;
    idle_all();
    model_reset();
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    cycle();

    // Directed vector table
    for (int i = 0; i < 21; i++) begin
      int d;
      d = tbl[i].dut;
      idle_all();
      for (int e = 0; e < NDUT; e++)
        for (int c = 0; c < 4; c++) t_data[e][c*W +: W] = dat(i, c);
      t_valid[d] = tbl[i].valid;
      t_sel[d]   = tbl[i].sel;
      t_ordy[d]  = tbl[i].ordy;
      #1;
      chk("tbl_in_ready", d, 32'(o_inr[d]), 32'(tbl[i].exp_rdy));
      cycle();
      chk("tbl_out_valid", d, 32'(o_valid[d]), 32'(tbl[i].exp_ov));
      chk("tbl_out_chan",  d, 32'(o_chan[d]),  32'(tbl[i].exp_chan));
      chk("tbl_out_data",  d, o_data[d],       dat(tbl[i].src_row, int'(tbl[i].exp_chan)));
    end

    // Reset while beats are held: rr loads ch2 (ptr->3), sel3 keeps its beat
    idle_all();
    t_valid[1] = 4'b0100;
    t_ordy[1]  = 1'b0;
    t_ordy[2]  = 1'b0;
    cycle();
    chk("pre_rst_valid_rr",  1, 32'(o_valid[1]), 32'd1);
    chk("pre_rst_valid_s3",  2, 32'(o_valid[2]), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_out_valid", d, 32'(o_valid[d]), 32'd0);
      chk("rst_out_data",  d, o_data[d],       32'd0);
      chk("rst_out_chan",  d, 32'(o_chan[d]),  32'd0);
      chk("rst_in_ready",  d, 32'(o_inr[d]),   32'd0);
    end
    t_valid[0] = 4'b1111;
    t_valid[1] = 4'b1111;
    @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) chk("rst_hold_valid", d, 32'(o_valid[d]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_all();
    cycle();
    for (int d = 0; d < NDUT; d++) chk("post_rst_no_beat", d, 32'(o_valid[d]), 32'd0);
    t_valid[1] = 4'b1001;
    cycle();
    chk("post_rst_ptr0_chan",  1, 32'(o_chan[1]),  32'd0);
    chk("post_rst_ptr0_valid", 1, 32'(o_valid[1]), 32'd1);

    // Random traffic against the model, with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < NDUT; d++) begin
        t_valid[d] = 4'($urandom);
        t_sel[d]   = 2'($urandom);
        t_ordy[d]  = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < 4; c++) t_data[d][c*W +: W] = $urandom;
      end
      if ($urandom_range(0, 299) == 0) async_reset_pulse();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muxn_reg.md
MUXN_REG -- requirements
Module: muxn_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width per channel in bits.
REQ-002 SHALL have parameter CHANNELS, default 4: number of input channels, range 2..16.
REQ-003 SHALL have parameter MODE, default 0: 0 = explicit select, 1 = round-robin arbitration.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_data, input, CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid, input, CHANNELS: per-channel valid.
REQ-008 SHALL have port in_ready, output, CHANNELS: per-channel ready, combinational.
REQ-009 SHALL have port sel, input, SW = max(1, clog2(CHANNELS)): channel select, used only when MODE=0.
REQ-010 SHALL have port out_data, output, WIDTH: registered selected data.
REQ-011 SHALL have port out_chan, output, SW: index of the channel that supplied out_data.
REQ-012 SHALL have port out_valid, output, 1: out_data/out_chan hold a beat.
REQ-013 SHALL have port out_ready, input, 1: downstream accept.

Function
REQ-014 SHALL hold a single output register stage; a beat is loaded when can_load = !out_valid | out_ready.
REQ-015 SHALL give 1-cycle latency: a beat accepted at edge N appears on out_data with out_valid high after edge N.
REQ-016 SHALL transfer on input channel i only when in_valid[i] & in_ready[i] in the same cycle.
REQ-017 SHALL transfer on the output only when out_valid & out_ready in the same cycle.
REQ-018 SHALL keep out_data and out_chan stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, in MODE=0, drive in_ready[sel] = can_load and all other in_ready bits 0.
REQ-020 SHALL, in MODE=0 with sel >= CHANNELS, drive all in_ready bits 0 and load nothing.
REQ-021 SHALL, in MODE=1, grant the first valid channel found searching upward from ptr with wrap from CHANNELS-1 to 0, and drive in_ready = can_load on the granted channel only.
REQ-022 SHALL, in MODE=1, set ptr to (granted index + 1) mod CHANNELS on each accepted beat; ptr SHALL be unchanged when there is no accept.
REQ-023 SHALL, on a drain and a load in the same cycle, load the new beat with no bubble, giving full throughput.
REQ-024 SHALL clear out_valid after a drain when there is no load.
REQ-025 SHALL not allow in_ready to depend on in_valid of the same channel in MODE=0.

Reset
REQ-026 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_chan=0 and ptr=0 immediately, independent of clk.
REQ-027 SHALL drop any beat held in the output register on a reset mid-operation; no beat SHALL be emitted after release until a new accept occurs.
REQ-028 SHALL drive in_ready all 0 while rst_n=0.

Structure
REQ-029 SHALL take the MODE encodings (MODE_SEL=0, MODE_RR=1) from the shared definitions file used by the datapath muxes.
REQ-030 SHALL implement round-robin grant in one sub-module, rr_arbiter (parameter CHANNELS; inputs req and ptr; output one-hot grant plus index), instantiated only when MODE=1.
REQ-031 SHALL build the data select as a generate-loop AND-OR over the one-hot grant; no per-bit hand instantiation.

Verification
REQ-032 SHALL pass this test: MODE=0, sel=2, in_valid=4'b0100, ch2=32'hDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=DEADBEEF, out_chan=2.
REQ-033 SHALL pass this test: MODE=0, out_ready=0 for 3 cycles after a load -> out_data stable, in_ready all 0; then out_ready=1 -> back-to-back beats with no bubble.
REQ-034 SHALL pass this test: MODE=1, in_valid=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0.
REQ-035 SHALL pass this test: MODE=1, ptr=3, in_valid=4'b0010 -> grant channel 1 (wrap) and ptr becomes 2.
REQ-036 SHALL pass this test: CHANNELS=3, MODE=0, sel=3 -> in_ready=0 and out_valid stays 0.
REQ-037 SHALL pass this test: rst_n asserted mid-cycle with out_valid=1 -> out_valid=0 and out_data=0 immediately, ptr=0 after release.
